// File: rtl/full_adder_2bit_if.sv
// Operand/result bundle for the registered triple-implementation adder.
// master drives operands and select; slave is the adder side.
interface full_adder_2bit_if #(
    parameter int WIDTH = 2
) ();
    logic             in_valid;
    logic [1:0]       style_sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             out_valid;
    logic             mismatch;

    modport master (
        output in_valid, style_sel, a, b,
        input  sum, carry, out_valid, mismatch
    );

    modport slave (
        input  in_valid, style_sel, a, b,
        output sum, carry, out_valid, mismatch
    );
endinterface

// File: rtl/full_adder_2bit.sv
// Registered WIDTH-bit adder built three ways (gates, dataflow, behavioural);
// style_sel picks the registered result and mismatch flags any disagreement.
module full_adder_2bit #(
    parameter int WIDTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    full_adder_2bit_if.slave  bus
);
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    assign op_a = bus.a;
    assign op_b = bus.b;

    // Gate-level ripple: half adder at bit 0, full adders above it.
    wire [WIDTH-1:0] gl_s;
    wire [WIDTH:1]   gl_c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_ha
            xor u_x0 (gl_s[0], op_a[0], op_b[0]);
            and u_a0 (gl_c[1], op_a[0], op_b[0]);
        end else begin : g_fa
            wire p, g, t;
            xor u_x0 (p, op_a[i], op_b[i]);
            xor u_x1 (gl_s[i], p, gl_c[i]);
            and u_a0 (g, op_a[i], op_b[i]);
            and u_a1 (t, p, gl_c[i]);
            or  u_o0 (gl_c[i+1], g, t);
        end
    end

    logic [WIDTH:0] gl_r;
    assign gl_r = {gl_c[WIDTH], gl_s};

    logic [WIDTH:0] df_r;
    assign df_r = {1'b0, op_a} + {1'b0, op_b};

    logic [WIDTH-1:0] bh_s;
    logic             bh_cy;
    logic [WIDTH:0]   bh_r;

    always_comb begin
        bh_s  = '0;
        bh_cy = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            bh_s[i] = op_a[i] ^ op_b[i] ^ bh_cy;
            bh_cy   = (op_a[i] & op_b[i]) | (bh_cy & (op_a[i] ^ op_b[i]));
        end
    end

    assign bh_r = {bh_cy, bh_s};

    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             out_valid_q;
    logic             mismatch_q, mismatch_d;
    logic [WIDTH:0]   sel_r;

    always_comb begin
        sel_r = bh_r;
        case (bus.style_sel)
            2'd0:    sel_r = gl_r;
            2'd1:    sel_r = df_r;
            default: sel_r = bh_r;
        endcase
    end

    // Idle cycles keep the last result visible; only out_valid drops.
    always_comb begin
        sum_d      = sum_q;
        carry_d    = carry_q;
        mismatch_d = mismatch_q;
        if (bus.in_valid) begin
            {carry_d, sum_d} = sel_r;
            mismatch_d       = (gl_r != df_r) || (df_r != bh_r);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            out_valid_q <= bus.in_valid;
            mismatch_q  <= mismatch_d;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;
    assign bus.out_valid = out_valid_q;
    assign bus.mismatch  = mismatch_q;
endmodule

// File: tb/tb_full_adder_2bit.sv
// Directed/exhaustive bench for full_adder_2bit at WIDTH 1, 2 and 8,
// with a scoreboard queue of expected {carry,sum} values.
module tb_full_adder_2bit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    full_adder_2bit_if #(.WIDTH(1)) bus1 ();
    full_adder_2bit_if #(.WIDTH(2)) bus2 ();
    full_adder_2bit_if #(.WIDTH(8)) bus8 ();

    full_adder_2bit #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    full_adder_2bit #(.WIDTH(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    full_adder_2bit #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    logic [31:0] sb_q[$];
    logic [31:0] last_r[9];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_out(input int d, output logic [31:0] res, output logic ov, output logic mm);
        res = '0;
        ov  = 1'b0;
        mm  = 1'b0;
        case (d)
            1: begin res = {30'b0, bus1.carry, bus1.sum}; ov = bus1.out_valid; mm = bus1.mismatch; end
            2: begin res = {29'b0, bus2.carry, bus2.sum}; ov = bus2.out_valid; mm = bus2.mismatch; end
            default: begin res = {23'b0, bus8.carry, bus8.sum}; ov = bus8.out_valid; mm = bus8.mismatch; end
        endcase
    endtask

    // One clock step on DUT of width d; checks the registered outputs after the edge.
    task automatic step(input int d, input bit v, input logic [1:0] sel,
                        input logic [15:0] av, input logic [15:0] bv, input string tag);
        logic [31:0] ea, eb, res, exp;
        logic        ov, mm;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        bus2.in_valid = 1'b0;
        bus8.in_valid = 1'b0;
        ea = 32'(av) & ((32'd1 << d) - 1);
        eb = 32'(bv) & ((32'd1 << d) - 1);
        case (d)
            1: begin bus1.in_valid = v; bus1.style_sel = sel; bus1.a = av[0];   bus1.b = bv[0];   end
            2: begin bus2.in_valid = v; bus2.style_sel = sel; bus2.a = av[1:0]; bus2.b = bv[1:0]; end
            default: begin bus8.in_valid = v; bus8.style_sel = sel; bus8.a = av[7:0]; bus8.b = bv[7:0]; end
        endcase
        if (v) sb_q.push_back(ea + eb);
        @(posedge clk);
        #1;
        read_out(d, res, ov, mm);
        if (v) begin
            chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hDEAD;
            last_r[d] = exp;
        end
        chk({tag, "_out_valid"}, {31'b0, ov}, {31'b0, v});
        chk({tag, "_result"}, res, last_r[d]);
        chk({tag, "_mismatch"}, {31'b0, mm}, 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        logic [31:0] res;
        logic        ov, mm;
        read_out(2, res, ov, mm);
        chk({tag, "_res"}, res, 32'd0);
        chk({tag, "_ov"}, {31'b0, ov}, 32'd0);
        chk({tag, "_mm"}, {31'b0, mm}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 9; i++) last_r[i] = '0;
        bus1.in_valid = 1'b0; bus1.style_sel = 2'd0; bus1.a = '0; bus1.b = '0;
        bus2.in_valid = 1'b0; bus2.style_sel = 2'd0; bus2.a = '0; bus2.b = '0;
        bus8.in_valid = 1'b0; bus8.style_sel = 2'd0; bus8.a = '0; bus8.b = '0;

        // Held in reset while inputs toggle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus2.in_valid = 1'b1;
            bus2.a = 2'($urandom_range(3));
            bus2.b = 2'($urandom_range(3));
            @(posedge clk);
            #1;
            chk_zero("rst_hold");
        end
        @(negedge clk);
        bus2.in_valid = 1'b0;
        rst_n = 1'b1;

        // Directed vectors per style.
        for (int s = 0; s < 3; s++) begin
            step(2, 1'b1, 2'(s), 16'd1, 16'd0, "dir_1p0");
            step(2, 1'b1, 2'(s), 16'd2, 16'd2, "dir_2p2");
            step(2, 1'b1, 2'(s), 16'd3, 16'd1, "dir_3p1");
        end

        // Exhaustive back-to-back.
        for (int s = 0; s < 4; s++)
            for (int a = 0; a < 4; a++)
                for (int b = 0; b < 4; b++)
                    step(2, 1'b1, 2'(s), 16'(a), 16'(b), "exh");

        // Hold across idle cycles with changing operands.
        step(2, 1'b1, 2'd0, 16'd2, 16'd1, "hold_cap");
        for (int i = 0; i < 3; i++)
            step(2, 1'b0, 2'(i), 16'($urandom), 16'($urandom), "hold_idle");

        // Select switch with constant operands.
        step(2, 1'b1, 2'd0, 16'd3, 16'd2, "sel0");
        step(2, 1'b1, 2'd2, 16'd3, 16'd2, "sel2");
        step(2, 1'b1, 2'd1, 16'd3, 16'd2, "sel1");

        // Asynchronous reset mid-cycle with a capture pending.
        @(negedge clk);
        bus2.in_valid = 1'b1; bus2.style_sel = 2'd1; bus2.a = 2'd3; bus2.b = 2'd3;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        @(posedge clk);
        #1;
        chk_zero("async_rst_edge");
        @(negedge clk);
        bus2.in_valid = 1'b0;
        rst_n = 1'b1;
        last_r[2] = '0;
        step(2, 1'b0, 2'd0, 16'd1, 16'd1, "post_rst_idle");
        step(2, 1'b1, 2'd3, 16'd3, 16'd3, "post_rst_3p3");

        // Other widths.
        for (int s = 0; s < 3; s++) begin
            step(1, 1'b1, 2'(s), 16'd1, 16'd1, "w1_1p1");
            step(8, 1'b1, 2'(s), 16'd200, 16'd100, "w8_200p100");
            step(8, 1'b1, 2'(s), 16'd255, 16'd255, "w8_255p255");
        end

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/full_adder_2bit.md
Name: full_adder_2bit

Overview:
- Registered WIDTH-bit unsigned adder producing a WIDTH-bit sum and a single carry-out.
- Computes the result three independent ways internally: gate-level ripple (primitive and/xor/or cells), continuous-assignment dataflow, and procedural behavioural.
- A select input chooses which result is registered to the outputs.
- A cross-check flag reports any disagreement between the three implementations, so the block serves as a self-checking arithmetic primitive.

Parameters:
- WIDTH, 2, operand and sum width in bits; legal range 1..16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid this cycle.
- style_sel  input  2  implementation select: 0 gate-level, 1 dataflow, 2 behavioural, 3 behavioural (reserved alias).
- a  input  WIDTH  unsigned operand A.
- b  input  WIDTH  unsigned operand B.
- sum  output  WIDTH  registered low WIDTH bits of a+b.
- carry  output  1  registered bit WIDTH of a+b (carry-out).
- out_valid  output  1  registered in_valid.
- mismatch  output  1  registered: the three internal results disagreed on the captured operands.

Behaviour:
- Reset: rst_n low asynchronously forces sum=0, carry=0, out_valid=0 and mismatch=0, independent of clk. Outputs hold 0 while rst_n is low.
- Release: the first capture occurs on the first rising clk edge with rst_n high.
- Arithmetic: {carry,sum} = a + b, computed at WIDTH+1 bits, unsigned, with no carry-in.
- Overflow: it wraps into carry. Example for WIDTH=2: 3+1 gives sum=0, carry=1.
- Gate-level path:
  - Bit 0 is a half adder (xor and and).
  - Bits 1..WIDTH-1 are full adders (two xor, two and, one or) rippled; the final ripple carry is the carry-out.
  - Generate it with a generate loop over WIDTH.
- Dataflow path: a single continuous assignment of the concatenated {carry,sum} to a+b.
- Behavioural path: a combinational always block with a loop over bits computing sum and carry procedurally.
- Latency: one cycle. When in_valid=1 at edge N, the result for the selected style appears on sum/carry after edge N, with out_valid=1.
- Idle cycles: when in_valid=0 at an edge, sum, carry and mismatch hold their previous values and out_valid=0.
- style_sel is sampled on the same edge as the operands. Changing it between transactions affects only subsequent captures.
- mismatch: on a valid capture it is 1 if any of the three {carry,sum} results differ, else 0. In correct RTL it must always be 0 after reset.
- Back-to-back in_valid: one result per cycle, no bubbles, no back-pressure.
- Reset asserted mid-stream: the pending capture is discarded and all outputs clear immediately.
- No X propagation from unselected paths: all three paths are always fully driven.

Test Plan:
- Reset: hold rst_n=0, toggle a/b/in_valid -> sum=0, carry=0, out_valid=0, mismatch=0. Assert rst_n low asynchronously mid-cycle -> outputs clear before the next edge.
- Directed vectors, WIDTH=2, style_sel=0, then 1, then 2:
  - a=1, b=0 -> sum=1, carry=0.
  - a=2, b=2 -> sum=0, carry=1.
  - a=3, b=1 -> sum=0, carry=1.
  - Each result appears one cycle after in_valid, with mismatch=0 throughout.
- Exhaustive: all 16 (a,b) pairs × all 4 style_sel values, back-to-back with in_valid=1 -> {carry,sum}=a+b every cycle, out_valid continuously 1, mismatch=0. Example: a=3, b=3 -> sum=2, carry=1.
- Hold: one valid capture with a=2, b=1 (sum=3, carry=0), then in_valid=0 for 3 cycles while a/b change randomly -> sum=3, carry=0 held, out_valid=0.
- Select switch: in consecutive cycles, style_sel 0→2→1 with a=3, b=2 -> sum=1, carry=1 on all three outputs cycles, no glitch between cycles.
- Parameter sweep: WIDTH=1 (a=1, b=1 -> sum=0, carry=1) and WIDTH=8 (a=200, b=100 -> sum=44, carry=1), with mismatch=0.
